// File: rtl/wave_read_scheduler.sv
// wave_read_scheduler
// Shares the single read port of the oscillator wave BRAM between the
// oscillator lanes, the HDMI visualiser and the debug reader.
//
// A free-running slot counter gives each oscillator lane one slot per frame.
// The last slot of the frame is shared between viz and debug. Every issued
// read carries a tag through a READ_LATENCY-deep pipeline. When the tag
// retires, the BRAM data is steered into the matching holding register and a
// one-cycle valid pulse is raised.
//
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   osc_is_on_in/index_in     per-lane enable and playback index
//   osc_data_out/valid_out    per-lane held sample and update pulse
//   viz_req_in/index_in       visualiser read request pulse and address
//   viz_data_out/valid_out    visualiser held sample and update pulse
//   debug_req_in/index_in     debug read request pulse and address
//   debug_data_out/valid_out  debug held sample and update pulse
//   load_busy_in              loader owns the BRAM; no reads are issued
//   bram_addr_out/en_out      registered BRAM read address and enable
//   bram_data_in              BRAM read data, READ_LATENCY after the address
//   frame_start_out           high in the cycle after slot 0 is issued
module wave_read_scheduler #(
    parameter int NUM_OSCILLATORS = 4,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int WW_WIDTH        = 18,
    parameter int READ_LATENCY    = 2
) (
    input  logic                                           clk_in,
    input  logic                                           rst_n_in,
    input  logic [NUM_OSCILLATORS-1:0]                     osc_is_on_in,
    input  logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]       osc_index_in,
    output logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0]   osc_data_out,
    output logic [NUM_OSCILLATORS-1:0]                     osc_valid_out,
    input  logic                                           viz_req_in,
    input  logic [WW_WIDTH-1:0]                            viz_index_in,
    output logic [SAMPLE_WIDTH-1:0]                        viz_data_out,
    output logic                                           viz_valid_out,
    input  logic                                           debug_req_in,
    input  logic [WW_WIDTH-1:0]                            debug_index_in,
    output logic [SAMPLE_WIDTH-1:0]                        debug_data_out,
    output logic                                           debug_valid_out,
    input  logic                                           load_busy_in,
    output logic [WW_WIDTH-1:0]                            bram_addr_out,
    output logic                                           bram_en_out,
    input  logic [SAMPLE_WIDTH-1:0]                        bram_data_in,
    output logic                                           frame_start_out
);

    localparam int SLOT_W = $clog2(NUM_OSCILLATORS + 1);
    localparam int LANE_W = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;
    localparam logic [SLOT_W-1:0] SHARED_SLOT = SLOT_W'(NUM_OSCILLATORS);

    typedef enum logic [1:0] {
        KIND_OSC = 2'd0,
        KIND_VIZ = 2'd1,
        KIND_DBG = 2'd2
    } kind_t;

    logic [SLOT_W-1:0]   r_slot;
    logic                r_vizPend;
    logic                r_dbgPend;
    logic [WW_WIDTH-1:0] r_vizIdx;
    logic [WW_WIDTH-1:0] r_dbgIdx;
    logic                r_arbViz;

    logic                r_tagValid [READ_LATENCY];
    kind_t               r_tagKind  [READ_LATENCY];
    logic [LANE_W-1:0]   r_tagLane  [READ_LATENCY];

    logic                w_isShared;
    logic                w_grantViz;
    logic                w_grantDbg;
    logic [WW_WIDTH-1:0] w_oscAddr;
    logic [LANE_W-1:0]   w_oscLane;
    logic                w_issueValid;
    logic [WW_WIDTH-1:0] w_issueAddr;
    kind_t               w_issueKind;
    logic [LANE_W-1:0]   w_issueLane;
    logic                w_retValid;
    kind_t               w_retKind;
    logic [LANE_W-1:0]   w_retLane;

    assign w_isShared = (r_slot == SHARED_SLOT);

    // Shared slot: a lone requester always wins; when both wait, the
    // round-robin pointer decides. A busy loader blocks any grant, so the
    // request stays pending and the pointer does not move.
    assign w_grantViz = w_isShared && !load_busy_in && r_vizPend && (!r_dbgPend || r_arbViz);
    assign w_grantDbg = w_isShared && !load_busy_in && r_dbgPend && (!r_vizPend || !r_arbViz);

    // Picks the oscillator lane that owns the current slot. A compare loop is
    // used so the shared slot value never indexes past the lane array.
    always_comb begin
        w_oscAddr = '0;
        w_oscLane = '0;
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
            if (r_slot == SLOT_W'(i)) begin
                w_oscAddr = osc_index_in[i];
                w_oscLane = LANE_W'(i);
            end
        end
    end

    // Chooses what is launched at this edge: an oscillator read, a viz or
    // debug grant, or nothing.
    always_comb begin
        w_issueValid = 1'b0;
        w_issueAddr  = '0;
        w_issueKind  = KIND_OSC;
        w_issueLane  = '0;
        if (!w_isShared) begin
            w_issueValid = !load_busy_in;
            w_issueAddr  = w_oscAddr;
            w_issueLane  = w_oscLane;
        end else if (w_grantViz) begin
            w_issueValid = 1'b1;
            w_issueAddr  = r_vizIdx;
            w_issueKind  = KIND_VIZ;
        end else if (w_grantDbg) begin
            w_issueValid = 1'b1;
            w_issueAddr  = r_dbgIdx;
            w_issueKind  = KIND_DBG;
        end
    end

    // The slot counter free-runs regardless of the loader so the frame
    // timing seen by the oscillators never drifts.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_slot          <= '0;
            bram_addr_out   <= '0;
            bram_en_out     <= 1'b0;
            frame_start_out <= 1'b0;
        end else begin
            r_slot          <= w_isShared ? '0 : r_slot + SLOT_W'(1);
            bram_addr_out   <= w_issueAddr;
            bram_en_out     <= w_issueValid;
            frame_start_out <= (r_slot == '0);
        end
    end

    // A request arriving in the same cycle as its grant is a fresh request,
    // so the set takes priority over the clear.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vizPend <= 1'b0;
            r_dbgPend <= 1'b0;
            r_vizIdx  <= '0;
            r_dbgIdx  <= '0;
            r_arbViz  <= 1'b1;
        end else begin
            if (viz_req_in) begin
                r_vizPend <= 1'b1;
                r_vizIdx  <= viz_index_in;
            end else if (w_grantViz) begin
                r_vizPend <= 1'b0;
            end
            if (debug_req_in) begin
                r_dbgPend <= 1'b1;
                r_dbgIdx  <= debug_index_in;
            end else if (w_grantDbg) begin
                r_dbgPend <= 1'b0;
            end
            if ((w_grantViz || w_grantDbg) && r_vizPend && r_dbgPend) begin
                r_arbViz <= ~r_arbViz;
            end
        end
    end

    // Tag pipeline mirroring the BRAM read latency; stage 0 holds the read
    // launched at the most recent edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tagValid[i] <= 1'b0;
                r_tagKind[i]  <= KIND_OSC;
                r_tagLane[i]  <= '0;
            end
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                r_tagValid[i] <= r_tagValid[i-1];
                r_tagKind[i]  <= r_tagKind[i-1];
                r_tagLane[i]  <= r_tagLane[i-1];
            end
            r_tagValid[0] <= w_issueValid;
            r_tagKind[0]  <= w_issueKind;
            r_tagLane[0]  <= w_issueLane;
        end
    end

    assign w_retValid = r_tagValid[READ_LATENCY-1];
    assign w_retKind  = r_tagKind[READ_LATENCY-1];
    assign w_retLane  = r_tagLane[READ_LATENCY-1];

    // Retiring tag steers the BRAM data to its owner. A lane that has been
    // switched off gets silence but still sees its update pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            osc_data_out    <= '0;
            osc_valid_out   <= '0;
            viz_data_out    <= '0;
            viz_valid_out   <= 1'b0;
            debug_data_out  <= '0;
            debug_valid_out <= 1'b0;
        end else begin
            osc_valid_out   <= '0;
            viz_valid_out   <= 1'b0;
            debug_valid_out <= 1'b0;
            if (w_retValid) begin
                case (w_retKind)
                    KIND_VIZ: begin
                        viz_data_out  <= bram_data_in;
                        viz_valid_out <= 1'b1;
                    end
                    KIND_DBG: begin
                        debug_data_out  <= bram_data_in;
                        debug_valid_out <= 1'b1;
                    end
                    default: begin
                        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
                            if (w_retLane == LANE_W'(i)) begin
                                osc_data_out[i]  <= osc_is_on_in[i] ? bram_data_in : '0;
                                osc_valid_out[i] <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wave_read_scheduler.sv
// tb_wave_read_scheduler
// Drives wave_read_scheduler with directed scenarios and random traffic and
// compares every output each cycle against a queue-based behavioural model.
// The BRAM is modelled as data = address + 1000 with a two-cycle latency.
module tb_wave_read_scheduler;

    localparam int N  = 4;
    localparam int SW = 16;
    localparam int WW = 18;
    localparam int RL = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [N-1:0]          oscIsOn = '1;
    logic [N-1:0][WW-1:0]  oscIndex = '0;
    logic [N-1:0][SW-1:0]  oscData;
    logic [N-1:0]          oscValid;
    logic                  vizReq = 1'b0;
    logic [WW-1:0]         vizIndex = '0;
    logic [SW-1:0]         vizData;
    logic                  vizValid;
    logic                  dbgReq = 1'b0;
    logic [WW-1:0]         dbgIndex = '0;
    logic [SW-1:0]         dbgData;
    logic                  dbgValid;
    logic                  loadBusy = 1'b0;
    logic [WW-1:0]         bramAddr;
    logic                  bramEn;
    logic [SW-1:0]         bramData;
    logic                  frameStart;

    int totalCount = 0;
    int badCount   = 0;

    wave_read_scheduler #(
        .NUM_OSCILLATORS(N), .SAMPLE_WIDTH(SW), .WW_WIDTH(WW), .READ_LATENCY(RL)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .osc_is_on_in(oscIsOn), .osc_index_in(oscIndex),
        .osc_data_out(oscData), .osc_valid_out(oscValid),
        .viz_req_in(vizReq), .viz_index_in(vizIndex),
        .viz_data_out(vizData), .viz_valid_out(vizValid),
        .debug_req_in(dbgReq), .debug_index_in(dbgIndex),
        .debug_data_out(dbgData), .debug_valid_out(dbgValid),
        .load_busy_in(loadBusy),
        .bram_addr_out(bramAddr), .bram_en_out(bramEn),
        .bram_data_in(bramData), .frame_start_out(frameStart)
    );

    always #5 clk = ~clk;

    // BRAM with two-cycle latency: address registered by the DUT, one more
    // register here, data presented combinationally.
    logic [WW-1:0] bramAddrPipe = '0;
    always @(posedge clk) bramAddrPipe <= bramAddr;
    assign bramData = SW'(bramAddrPipe + WW'(1000));

    // Behavioural model state
    typedef struct {
        int            retireEdge;
        int            kind;      // 0 osc, 1 viz, 2 debug
        int            lane;
        logic [WW-1:0] addr;
    } flight_t;

    flight_t       inFlight[$];
    int            mEdge;
    int            mSlot;
    bit            mVizPend, mDbgPend, mArbViz;
    logic [WW-1:0] mVizIdx, mDbgIdx;
    logic [SW-1:0] mOscData [N];
    logic [N-1:0]  mOscValid;
    logic [SW-1:0] mVizData, mDbgData;
    bit            mVizValid, mDbgValid, mEn, mFrame;
    logic [WW-1:0] mAddr;

    int vizPulses = 0, dbgPulses = 0, framePulses = 0, lane2Pulses = 0;
    int enCount = 0, validCount = 0;

    function automatic logic [SW-1:0] bramWord(input logic [WW-1:0] a);
        return SW'(a + WW'(1000));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        inFlight.delete();
        mEdge = 0; mSlot = 0;
        mVizPend = 0; mDbgPend = 0; mArbViz = 1;
        mVizIdx = '0; mDbgIdx = '0;
        for (int i = 0; i < N; i++) mOscData[i] = '0;
        mOscValid = '0; mVizData = '0; mDbgData = '0;
        mVizValid = 0; mDbgValid = 0; mEn = 0; mFrame = 0; mAddr = '0;
    endtask

    task automatic modelStep();
        flight_t f;
        int pick;
        mOscValid = '0; mVizValid = 0; mDbgValid = 0;
        while (inFlight.size() > 0 && inFlight[0].retireEdge == mEdge) begin
            f = inFlight.pop_front();
            if (f.kind == 1) begin
                mVizData = bramWord(f.addr); mVizValid = 1;
            end else if (f.kind == 2) begin
                mDbgData = bramWord(f.addr); mDbgValid = 1;
            end else begin
                mOscData[f.lane] = oscIsOn[f.lane] ? bramWord(f.addr) : '0;
                mOscValid[f.lane] = 1'b1;
            end
        end
        mFrame = (mSlot == 0);
        mEn = 0;
        pick = 0;
        if (!loadBusy) begin
            if (mSlot < N) begin
                mEn = 1; mAddr = oscIndex[mSlot];
                inFlight.push_back('{mEdge + RL, 0, mSlot, oscIndex[mSlot]});
            end else begin
                if (mVizPend && mDbgPend) begin
                    pick = mArbViz ? 1 : 2;
                    mArbViz = !mArbViz;
                end else if (mVizPend) pick = 1;
                else if (mDbgPend) pick = 2;
                if (pick == 1) begin
                    mEn = 1; mAddr = mVizIdx; mVizPend = 0;
                    inFlight.push_back('{mEdge + RL, 1, 0, mVizIdx});
                end else if (pick == 2) begin
                    mEn = 1; mAddr = mDbgIdx; mDbgPend = 0;
                    inFlight.push_back('{mEdge + RL, 2, 0, mDbgIdx});
                end
            end
        end
        if (vizReq) begin mVizPend = 1; mVizIdx = vizIndex; end
        if (dbgReq) begin mDbgPend = 1; mDbgIdx = dbgIndex; end
        mSlot = (mSlot + 1) % (N + 1);
        mEdge++;
    endtask

    task automatic compareModel();
        checkOutput("bram_en", 32'(bramEn), 32'(mEn));
        if (mEn) checkOutput("bram_addr", 32'(bramAddr), 32'(mAddr));
        if (!rst_n) checkOutput("bram_addr_rst", 32'(bramAddr), 32'd0);
        checkOutput("frame_start", 32'(frameStart), 32'(mFrame));
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("osc_data%0d", i), 32'(oscData[i]), 32'(mOscData[i]));
            checkOutput($sformatf("osc_valid%0d", i), 32'(oscValid[i]), 32'(mOscValid[i]));
        end
        checkOutput("viz_data", 32'(vizData), 32'(mVizData));
        checkOutput("viz_valid", 32'(vizValid), 32'(mVizValid));
        checkOutput("debug_data", 32'(dbgData), 32'(mDbgData));
        checkOutput("debug_valid", 32'(dbgValid), 32'(mDbgValid));
        checkOutput("valid_onehot", 32'($countones({oscValid, vizValid, dbgValid}) <= 1), 32'd1);
        if (rst_n) begin
            vizPulses   += int'(vizValid);
            dbgPulses   += int'(dbgValid);
            framePulses += int'(frameStart);
            lane2Pulses += int'(oscValid[2]);
            enCount     += int'(bramEn);
            validCount  += $countones({oscValid, vizValid, dbgValid});
        end
    endtask

    // Single compare process: model advances on each edge (or resets with
    // the DUT), outputs are compared 1 time unit later.
    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep();
            #1;
            compareModel();
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input int nCycles);
        repeat (nCycles) @(negedge clk);
    endtask

    int snapA, snapB, snapC;
    int busyLeft;
    bit aligned;

    initial begin
        for (int i = 0; i < N; i++) oscIndex[i] = WW'(10 * (i + 1));
        #1 rst_n = 1'b0;
        applyStimulus(3);
        rst_n = 1'b1;
        @(posedge clk); #2;
        checkOutput("first_frame_start", 32'(frameStart), 32'd1);
        checkOutput("first_addr", 32'(bramAddr), 32'd10);
        checkOutput("first_en", 32'(bramEn), 32'd1);

        $display("[TB] oscillator frame");
        applyStimulus(12);
        for (int i = 0; i < N; i++)
            checkOutput($sformatf("osc_lit%0d", i), 32'(oscData[i]), 32'(1010 + 10 * i));
        snapA = framePulses;
        applyStimulus(20);
        checkOutput("frame_period", 32'(framePulses - snapA), 32'd4);

        $display("[TB] shared slot alternation");
        vizReq = 1; vizIndex = 100; dbgReq = 1; dbgIndex = 200;
        applyStimulus(10);
        snapA = vizPulses; snapB = dbgPulses;
        applyStimulus(20);
        checkOutput("viz_period", 32'(vizPulses - snapA), 32'd2);
        checkOutput("dbg_period", 32'(dbgPulses - snapB), 32'd2);
        checkOutput("viz_lit", 32'(vizData), 32'd1100);
        checkOutput("dbg_lit", 32'(dbgData), 32'd1200);
        vizReq = 0; dbgReq = 0;

        $display("[TB] lane 2 off");
        applyStimulus(15);
        oscIsOn[2] = 1'b0;
        applyStimulus(10);
        snapA = lane2Pulses;
        applyStimulus(10);
        checkOutput("lane2_off", 32'(oscData[2]), 32'd0);
        checkOutput("lane2_pulses", 32'(lane2Pulses - snapA), 32'd2);
        checkOutput("lane1_on", 32'(oscData[1]), 32'd1020);
        oscIsOn[2] = 1'b1;

        $display("[TB] viz latest index wins");
        aligned = 0;
        for (int i = 0; i < 2 * (N + 1) && !aligned; i++) begin
            @(negedge clk);
            if (mSlot == 0) aligned = 1;
        end
        checkOutput("align_slot0", 32'(aligned), 32'd1);
        snapA = vizPulses;
        vizReq = 1; vizIndex = 5;
        @(negedge clk);
        vizIndex = 7;
        @(negedge clk);
        vizReq = 0;
        applyStimulus(10);
        checkOutput("viz_one_read", 32'(vizPulses - snapA), 32'd1);
        checkOutput("viz_latest", 32'(vizData), 32'd1007);

        $display("[TB] loader busy");
        @(negedge clk);
        loadBusy = 1; vizReq = 1; vizIndex = 100;
        snapA = enCount;
        @(negedge clk);
        vizReq = 0;
        @(negedge clk);
        snapB = validCount;
        applyStimulus(10);
        checkOutput("busy_en", 32'(enCount - snapA), 32'd0);
        checkOutput("busy_valids", 32'(validCount - snapB), 32'd0);
        checkOutput("busy_hold", 32'(vizData), 32'd1007);
        loadBusy = 0;
        snapC = vizPulses;
        applyStimulus(10);
        checkOutput("after_busy_viz", 32'(vizData), 32'd1100);
        checkOutput("after_busy_pulse", 32'(vizPulses - snapC), 32'd1);

        $display("[TB] random traffic");
        busyLeft = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c == 300) begin
                #2 rst_n = 1'b0;
                applyStimulus(3);
                rst_n = 1'b1;
                @(posedge clk); #2;
                checkOutput("rst_frame_start", 32'(frameStart), 32'd1);
                @(negedge clk);
            end
            for (int i = 0; i < N; i++) begin
                oscIndex[i] = WW'($urandom);
                oscIsOn[i]  = ($urandom_range(0, 7) != 0);
            end
            vizReq   = ($urandom_range(0, 3) == 0);
            vizIndex = WW'($urandom);
            dbgReq   = ($urandom_range(0, 3) == 0);
            dbgIndex = WW'($urandom);
            if (busyLeft > 0) begin
                busyLeft--;
                loadBusy = 1;
            end else if ($urandom_range(0, 29) == 0) begin
                busyLeft = $urandom_range(1, 15);
                loadBusy = 1;
            end else begin
                loadBusy = 0;
            end
        end
        vizReq = 0; dbgReq = 0; loadBusy = 0;
        applyStimulus(20);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
